fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, FSM states,
// default reset PC and the instruction-queue entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue of {instruction, pc+4} entries with
// push/pop/flush; flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic [CW-1:0] count,
  output logic        empty,
  output logic        full
);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: fetch PC, queue of fetched words, IF/ID register, and a
// RUN/DRAIN FSM that swallows the in-flight response after a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter  int          QDEPTH   = 2,
  localparam int          CW       = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          id_stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   dinst,
  output logic [31:0]   dpc4,
  output logic          dvalid,
  output fetch_state_t  dbg_state,
  output logic [CW-1:0] dbg_fifo_count
);

  // Memory handshake: a response is taken in any cycle with imem_req && imem_ack;
  // imem_addr stays constant from the cycle imem_req rises until that cycle.
  fetch_state_t state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  dinst_q, dinst_d;
  logic [31:0]  dpc4_q, dpc4_d;
  logic         dvalid_q, dvalid_d;

  logic         fifo_push, fifo_pop, fifo_flush;
  fifo_entry_t  fifo_push_data, fifo_head;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty, fifo_full;
  logic         accept;

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      imem_req = (state_q == ST_DRAIN) ? 1'b1 : !fifo_full;
    end
  end

  assign imem_addr      = (state_q == ST_DRAIN) ? drain_addr_q : fpc_q;
  assign accept         = imem_req && imem_ack;
  assign fifo_push_data = '{inst: imem_rdata, pc4: fpc_q + 32'd4};

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    drain_addr_d = drain_addr_q;
    dinst_d      = dinst_q;
    dpc4_d       = dpc4_q;
    dvalid_d     = dvalid_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    if (redirect) begin
      fifo_flush = 1'b1;
      dinst_d    = NOP_INST;
      dvalid_d   = 1'b0;
      fpc_d      = redirect_pc;
      if (state_q == ST_RUN) begin
        if (imem_req && !imem_ack) begin
          state_d      = ST_DRAIN;
          drain_addr_d = fpc_q;
        end
      end else if (imem_ack) begin
        // The old in-flight response arrives now, so nothing is left to drain.
        state_d = ST_RUN;
      end
    end else begin
      if (state_q == ST_RUN) begin
        if (accept) begin
          fifo_push = 1'b1;
          fpc_d     = fpc_q + 32'd4;
        end
      end else if (imem_ack) begin
        state_d = ST_RUN;
      end
      if (!id_stall) begin
        if (!fifo_empty) begin
          dinst_d  = fifo_head.inst;
          dpc4_d   = fifo_head.pc4;
          dvalid_d = 1'b1;
          fifo_pop = 1'b1;
        end else begin
          dinst_d  = NOP_INST;
          dvalid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      fpc_q        <= RESET_PC;
      drain_addr_q <= RESET_PC;
      dinst_q      <= NOP_INST;
      dpc4_q       <= 32'h0;
      dvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      drain_addr_q <= drain_addr_d;
      dinst_q      <= dinst_d;
      dpc4_q       <= dpc4_d;
      dvalid_q     <= dvalid_d;
    end
  end

  assign dinst          = dinst_q;
  assign dpc4           = dpc4_q;
  assign dvalid         = dvalid_q;
  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written
// sequences for wait-state drain, redirect in DRAIN, PC wrap and mid-request reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         id_stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  dinst;
  logic [31:0]  dpc4;
  logic         dvalid;
  fetch_state_t dbg_state;
  logic [1:0]   dbg_fifo_count;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .dinst          (dinst),
    .dpc4           (dpc4),
    .dvalid         (dvalid),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a, distinct from NOP for every a.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = inst_of(imem_addr);

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs after the falling edge, let outputs settle
  task automatic step(input logic r, input logic ack, input logic stall,
                      input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst         = r;
    imem_ack    = ack;
    id_stall    = stall;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_req0", 32'(imem_req), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_req1", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_dvalid", 32'(dvalid), 32'h0);
    chk("rst_dinst", dinst, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_count", 32'(dbg_fifo_count), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
  endtask

  typedef struct {
    logic        rst, ack, stall, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        dvalid;
    logic [31:0] dinst, dpc4, count;
  } vec_t;

  vec_t tbl [20];

  initial begin
    rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    //           rst   ack   stall redir rpc          req   addr          dv    dinst                dpc4       count
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,             32'h0,     32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0,      1'b0, 32'h0,             32'h0,     32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h4,      1'b0, 32'h0,             32'h0,     32'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h8,      1'b1, inst_of(32'h0),    32'h4,     32'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'hC,      1'b1, inst_of(32'h4),    32'h8,     32'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h10,     1'b1, inst_of(32'h8),    32'hC,     32'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h14,     1'b1, inst_of(32'h8),    32'hC,     32'd2};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h14,     1'b1, inst_of(32'h8),    32'hC,     32'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h14,     1'b1, inst_of(32'h8),    32'hC,     32'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h14,     1'b1, inst_of(32'h8),    32'hC,     32'd2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h14,     1'b1, inst_of(32'hC),    32'h10,    32'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h18,     1'b1, inst_of(32'h10),   32'h14,    32'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b1, inst_of(32'h14),   32'h18,    32'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100,    1'b0, 32'h20,     1'b1, inst_of(32'h14),   32'h18,    32'd2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0,             32'h18,    32'd0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h104,    1'b0, 32'h0,             32'h18,    32'd1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40,     1'b1, 32'h108,    1'b1, inst_of(32'h100),  32'h104,   32'd1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h40,     1'b0, 32'h0,             32'h104,   32'd0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h44,     1'b0, 32'h0,             32'h104,   32'd1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h48,     1'b1, inst_of(32'h40),   32'h44,    32'd1};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].ack, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("v%0d_req", i),    32'(imem_req),       32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),   imem_addr,           tbl[i].addr);
      chk($sformatf("v%0d_dvalid", i), 32'(dvalid),         32'(tbl[i].dvalid));
      chk($sformatf("v%0d_dinst", i),  dinst,               tbl[i].dinst);
      chk($sformatf("v%0d_dpc4", i),   dpc4,                tbl[i].dpc4);
      chk($sformatf("v%0d_count", i),  32'(dbg_fifo_count), tbl[i].count);
      chk($sformatf("v%0d_state", i),  32'(dbg_state),      32'(ST_RUN));
    end

    // Three wait cycles, redirect to 0x200 during wait cycle 1.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drn_w0_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    chk("drn_w1_req", 32'(imem_req), 32'h1);
    chk("drn_w1_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drn_w2_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("drn_w2_req", 32'(imem_req), 32'h1);
    chk("drn_w2_addr", imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drn_ack_addr", imem_addr, 32'h0);
    chk("drn_ack_dvalid", 32'(dvalid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drn_r0_state", 32'(dbg_state), 32'(ST_RUN));
    chk("drn_r0_addr", imem_addr, 32'h200);
    chk("drn_r0_dvalid", 32'(dvalid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drn_r1_addr", imem_addr, 32'h204);
    chk("drn_r1_dvalid", 32'(dvalid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drn_r2_dvalid", 32'(dvalid), 32'h1);
    chk("drn_r2_dinst", dinst, inst_of(32'h200));
    chk("drn_r2_dpc4", dpc4, 32'h204);

    // Second redirect while draining replaces the target and stays in DRAIN.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    chk("rdd_c0_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
    chk("rdd_c1_state", 32'(dbg_state), 32'(ST_DRAIN));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rdd_c2_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("rdd_c2_addr", imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rdd_c3_state", 32'(dbg_state), 32'(ST_RUN));
    chk("rdd_c3_addr", imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pre_dpc4", dpc4, 32'h4);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_state", 32'(dbg_state), 32'(ST_RUN));
    chk("wrap_count", 32'(dbg_fifo_count), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_bubble_dpc4", dpc4, 32'h8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_dinst", dinst, inst_of(32'hFFFF_FFFC));
    chk("wrap_dpc4", dpc4, 32'h0);
    chk("wrap_dvalid", 32'(dvalid), 32'h1);

    // Reset while a request is outstanding, then a response right after release.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_addr_before", imem_addr, 32'h8);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_req_after", 32'(imem_req), 32'h1);
    chk("mid_addr_after", imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_addr_next", imem_addr, 32'h4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_dinst", dinst, inst_of(32'h0));
    chk("mid_dvalid", 32'(dvalid), 32'h1);
    chk("mid_dpc4", dpc4, 32'h4);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
